// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a time,
// and holds the fetched word in the IF/ID register with a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_BUF  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic            buf_valid;
  logic [XLEN-1:0] buf_data;
  logic [XLEN-1:0] buf_pc;

  logic            handshake;
  logic            slot_free;
  logic [XLEN-1:0] redir_target;
  logic            word_avail;
  logic [XLEN-1:0] word_data;
  logic [XLEN-1:0] word_pc;
  logic            unused_redirect_lsb;

  assign handshake           = imem_req_valid && imem_req_ready;
  assign slot_free           = !instr_valid || !stall;
  assign redir_target        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request channel is a pure function of state and the PC register
  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;

  // Word offered to IF/ID this cycle: the skid buffer wins over a fresh response
  always_comb begin
    word_avail = 1'b0;
    word_data  = imem_resp_data;
    word_pc    = fetch_pc;
    if (state == S_BUF) begin
      word_avail = buf_valid;
      word_data  = buf_data;
      word_pc    = buf_pc;
    end else if (state == S_WAIT && imem_resp_valid) begin
      word_avail = 1'b1;
    end
  end

  // Next-state and next-PC
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_REQ: begin
        if (handshake) begin
          pc_nxt    = pc + WORD_BYTES;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_nxt = slot_free ? S_REQ : S_BUF;
        end
      end
      S_BUF: begin
        if (slot_free) begin
          state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase

    // Redirect overrides everything; an in-flight request must be drained first
    if (redirect_valid) begin
      pc_nxt = redir_target;
      case (state)
        S_REQ:   state_nxt = handshake ? S_DROP : S_REQ;
        S_WAIT:  state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        S_BUF:   state_nxt = S_REQ;
        S_DROP:  state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (handshake) begin
        fetch_pc <= pc;
      end
    end
  end

  // Skid buffer catches a response that arrives while IF/ID is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      buf_pc    <= '0;
    end else if (redirect_valid) begin
      buf_valid <= 1'b0;
    end else if (state == S_WAIT && imem_resp_valid && !slot_free) begin
      buf_valid <= 1'b1;
      buf_data  <= imem_resp_data;
      buf_pc    <= fetch_pc;
    end else if (state == S_BUF && slot_free) begin
      buf_valid <= 1'b0;
    end
  end

  // IF/ID register: redirect, then stall-hold, then load, else drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_pc_plus4 <= WORD_BYTES;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
    end else if (stall && instr_valid) begin
      instr_valid <= instr_valid;
    end else if (word_avail) begin
      instr_valid    <= 1'b1;
      instr          <= word_data;
      instr_pc       <= word_pc;
      instr_pc_plus4 <= word_pc + WORD_BYTES;
    end else begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and holds the fetched word in the IF/ID register. Its `instr` output is the instruction word consumed by the decode stage, including the immediate generator. It also absorbs hazard-unit stalls and execute-stage redirects (branches, JAL/JALR) without losing or duplicating instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_addr  out  32  fetch byte address, always word aligned
- imem_resp_valid  in  1  read data valid; arrives at least 1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- stall  in  1  decode cannot take `instr` this cycle; holds the IF/ID register
- redirect_valid  in  1  control-flow change from execute
- redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0
- instr_valid  out  1  IF/ID register holds a live instruction
- instr  out  32  IF/ID instruction word
- instr_pc  out  32  address of `instr`
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32

## Operation
- Only one memory request is outstanding at a time. A one-entry skid buffer (data + pc) catches a response that arrives while the IF/ID register is stalled.
- FSM states: S_REQ, S_WAIT, S_DROP, S_BUF.
  - S_REQ:
    - Drive `imem_req_valid`=1 with `imem_addr`=pc.
    - On valid&ready: pc <= pc+4 and go to S_WAIT.
  - S_WAIT:
    - On resp_valid, if the IF/ID slot is free (!instr_valid || !stall): load IF/ID and go to S_REQ.
    - On resp_valid, if the slot is not free: load the skid buffer and go to S_BUF.
  - S_BUF:
    - No request is issued.
    - When !stall: move the buffer into IF/ID and go to S_REQ.
  - S_DROP:
    - Waiting for the response to a killed request.
    - On resp_valid: discard the data and go to S_REQ.
- IF/ID consumption: an instruction is taken by decode in any cycle with instr_valid && !stall.
- IF/ID update, evaluated each cycle in this priority order:
  1. redirect → instr_valid <= 0.
  2. stall && instr_valid → hold.
  3. new word available (S_BUF, or S_WAIT with resp_valid) → load it with its pc.
  4. Otherwise → instr_valid <= 0.
- Redirect: highest priority, and stall does not block it.
  - pc <= {redirect_pc[31:2], 2'b00}; IF/ID and the skid buffer are invalidated.
  - Next state by current state:
    - S_REQ with handshake in the same cycle → S_DROP (the accepted request was for the old path).
    - S_REQ without handshake → S_REQ.
    - S_WAIT without resp_valid → S_DROP.
    - S_WAIT with resp_valid → S_REQ (data discarded).
    - S_BUF → S_REQ.
    - S_DROP without resp_valid → stays S_DROP; pc is still updated.
    - S_DROP with resp_valid → S_REQ.
- resp_valid in S_REQ or S_BUF is a protocol violation: ignored, no state change.
- pc increments wrap from 32'hFFFF_FFFC to 0.

## Timing
- Reset values:
  - pc = RESET_PC, state = S_REQ.
  - imem_req_valid = 1 (combinational from state), imem_addr = RESET_PC.
  - instr_valid = 0, instr = 0, instr_pc = 0, instr_pc_plus4 = 4, skid buffer invalid.
- Reset asserted mid-operation forces this reset state immediately. An outstanding response arriving after reset deasserts lands in S_REQ and is ignored.
- Latency: request accepted at edge N, response at cycle N+k (k≥1) → instr_valid at edge N+k+1.
- Peak throughput: one instruction per 2 cycles with ready=1 and k=1. The next request is issued in the cycle after the response.
- Redirect asserted in cycle N → imem_addr = redirect target no earlier than cycle N+1, and only once any killed response has drained.
- imem_addr and imem_req_valid must stay stable while valid && !ready, unless a redirect occurs.

## Test plan
- Reset, ready=1, 1-cycle memory: addresses 0,4,8 are requested; instr_valid pulses carry instr_pc 0,4,8 with instr_pc_plus4 4,8,12.
- Backpressure: ready=0 for 3 cycles at address 0x10 → imem_addr holds 0x10; the fetch completes after ready rises, with no duplicate and no skip.
- Stall with response in flight: stall held high while the response for 0x8 arrives → the word goes to the skid buffer and no new request is issued. Stall drops → IF/ID gets 0x8, then fetch of 0xC begins.
- Redirect while waiting: redirect_pc=0x103 asserted during S_WAIT for 0x20 → the 0x20 response is discarded, then 0x100 is requested and delivered with instr_pc=0x100.
- Redirect with stall high and IF/ID plus buffer full → both are invalidated, instr_valid=0 next cycle, and fetch resumes at the target.
- Async reset pulse mid S_WAIT → outputs return to reset values without a clock edge. A late resp_valid is ignored and the first delivered instr_pc is RESET_PC.
